bus_arbiter: RTL and testbench

- Shares the single synchronous memory bus between two bus masters: the CPU (master 0) and a loader/DMA port (master 1).
- Arbitration is round-robin, with one transaction in flight at a time.
- Sequences each access against a memory with fixed read latency, returns read data, and pulses an acknowledge to the granted master.
- Sits between the masters and the memory/peripheral bus, at the top level of the design.

---
 rtl/bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one synchronous memory bus between
// two masters (master 0 = CPU, master 1 = loader/DMA). One transaction is in
// flight at a time. Each access is sequenced against a fixed-latency memory,
// read data is returned, and a one-cycle ack (plus error for unaligned
// addresses) is pulsed to the granted master.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   m0*/m1*                     master request/WE/address/write data in;
//                               read data, ack and error pulses out
//   busAddress/busDataOut/
//   busWriteEnable/busDataIn    memory bus
//   grant                       one-hot owner of current transaction, 0 idle
module bus_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0Request,
  input  logic                  m0WriteEnable,
  input  logic [ADDR_WIDTH-1:0] m0Address,
  input  logic [31:0]           m0DataOut,
  output logic [31:0]           m0DataIn,
  output logic                  m0Ack,
  output logic                  m0Error,
  input  logic                  m1Request,
  input  logic                  m1WriteEnable,
  input  logic [ADDR_WIDTH-1:0] m1Address,
  input  logic [31:0]           m1DataOut,
  output logic [31:0]           m1DataIn,
  output logic                  m1Ack,
  output logic                  m1Error,
  output logic [ADDR_WIDTH-1:0] busAddress,
  output logic [31:0]           busDataOut,
  output logic                  busWriteEnable,
  input  logic [31:0]           busDataIn,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic                  last_grant;   // 0: master 0 was last, 1: master 1
  logic                  lat_we;
  logic [2:0]            count;

  logic                  start;
  logic                  take_m1;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [31:0]           sel_data;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    take_m1    = 1'b0;
    sel_addr   = m0Address;
    sel_we     = m0WriteEnable;
    sel_data   = m0DataOut;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (m0Request || m1Request) begin
          start   = 1'b1;
          // On contention the master that did not win last time goes first.
          take_m1 = m1Request && (!m0Request || !last_grant);
          if (take_m1) begin
            sel_addr = m1Address;
            sel_we   = m1WriteEnable;
            sel_data = m1DataOut;
          end
          misaligned = (sel_addr[1:0] != 2'b00);
          state_next = misaligned ? RESP : ACCESS;
        end
      end
      ACCESS:  state_next = WAIT;
      WAIT:    if (count == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      lat_we         <= 1'b0;
      count          <= '0;
      grant          <= '0;
      busAddress     <= '0;
      busDataOut     <= '0;
      busWriteEnable <= 1'b0;
      m0DataIn       <= '0;
      m1DataIn       <= '0;
      m0Ack          <= 1'b0;
      m1Ack          <= 1'b0;
      m0Error        <= 1'b0;
      m1Error        <= 1'b0;
    end else begin
      state          <= state_next;
      m0Ack          <= 1'b0;
      m1Ack          <= 1'b0;
      m0Error        <= 1'b0;
      m1Error        <= 1'b0;
      busWriteEnable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            grant      <= take_m1 ? 2'b10 : 2'b01;
            last_grant <= take_m1;
            lat_we     <= sel_we;
            // Ack/error are registered, so they are raised on the edge that
            // enters RESP; an unaligned request skips the bus entirely.
            if (misaligned) begin
              if (take_m1) begin
                m1Ack   <= 1'b1;
                m1Error <= 1'b1;
              end else begin
                m0Ack   <= 1'b1;
                m0Error <= 1'b1;
              end
            end else begin
              busAddress     <= sel_addr;
              busDataOut     <= sel_data;
              busWriteEnable <= sel_we;
            end
          end
        end
        ACCESS: begin
          count <= 3'(MEM_LATENCY - 1);
        end
        WAIT: begin
          if (count == '0) begin
            if (grant[1]) begin
              if (!lat_we) m1DataIn <= busDataIn;
              m1Ack <= 1'b1;
            end else begin
              if (!lat_we) m0DataIn <= busDataIn;
              m0Ack <= 1'b1;
            end
          end else begin
            count <= count - 3'd1;
          end
        end
        RESP: begin
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: two instances (MEM_LATENCY=1 and 3), each with a
// behavioural memory; expected ack results go through a scoreboard queue.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index [dut][master]
  logic        req    [2][2];
  logic        wen    [2][2];
  logic [31:0] maddr  [2][2];
  logic [31:0] mwdata [2][2];
  logic [31:0] mrdata [2][2];
  logic        mack   [2][2];
  logic        merr   [2][2];
  logic [31:0] bus_addr  [2];
  logic [31:0] bus_wdata [2];
  logic [31:0] bus_rdata [2];
  logic        bus_we    [2];
  logic [1:0]  grant     [2];

  bus_arbiter #(.MEM_LATENCY(1), .ADDR_WIDTH(32)) u_dut_l1 (
    .clk(clk), .reset(rst),
    .m0Request(req[0][0]), .m0WriteEnable(wen[0][0]), .m0Address(maddr[0][0]),
    .m0DataOut(mwdata[0][0]), .m0DataIn(mrdata[0][0]), .m0Ack(mack[0][0]), .m0Error(merr[0][0]),
    .m1Request(req[0][1]), .m1WriteEnable(wen[0][1]), .m1Address(maddr[0][1]),
    .m1DataOut(mwdata[0][1]), .m1DataIn(mrdata[0][1]), .m1Ack(mack[0][1]), .m1Error(merr[0][1]),
    .busAddress(bus_addr[0]), .busDataOut(bus_wdata[0]), .busWriteEnable(bus_we[0]),
    .busDataIn(bus_rdata[0]), .grant(grant[0])
  );

  bus_arbiter #(.MEM_LATENCY(3), .ADDR_WIDTH(32)) u_dut_l3 (
    .clk(clk), .reset(rst),
    .m0Request(req[1][0]), .m0WriteEnable(wen[1][0]), .m0Address(maddr[1][0]),
    .m0DataOut(mwdata[1][0]), .m0DataIn(mrdata[1][0]), .m0Ack(mack[1][0]), .m0Error(merr[1][0]),
    .m1Request(req[1][1]), .m1WriteEnable(wen[1][1]), .m1Address(maddr[1][1]),
    .m1DataOut(mwdata[1][1]), .m1DataIn(mrdata[1][1]), .m1Ack(mack[1][1]), .m1Error(merr[1][1]),
    .busAddress(bus_addr[1]), .busDataOut(bus_wdata[1]), .busWriteEnable(bus_we[1]),
    .busDataIn(bus_rdata[1]), .grant(grant[1])
  );

  // Memories: registered read, delayed to give exactly MEM_LATENCY cycles.
  logic [31:0] mem [2][256];
  logic        load_en = 1'b0;
  int          load_d = 0;
  logic [7:0]  load_idx = '0;
  logic [31:0] load_val = '0;
  logic [31:0] rd0, rd1a, rd1b, rd1c;

  always @(posedge clk) begin
    if (load_en) mem[load_d][load_idx] <= load_val;
    if (bus_we[0]) mem[0][bus_addr[0][9:2]] <= bus_wdata[0];
    if (bus_we[1]) mem[1][bus_addr[1][9:2]] <= bus_wdata[1];
    rd0  <= mem[0][bus_addr[0][9:2]];
    rd1a <= mem[1][bus_addr[1][9:2]];
    rd1b <= rd1a;
    rd1c <= rd1b;
  end
  assign bus_rdata[0] = rd0;
  assign bus_rdata[1] = rd1c;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic mem_load(input int d, input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    load_en  = 1'b1;
    load_d   = d;
    load_idx = addr[9:2];
    load_val = val;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Drives one transaction on one master and records what the bus did.
  // n = cycles from the request being issued to the ack (-1 on timeout).
  task automatic xact(input int d, input int m, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, output int n, output logic [31:0] rd,
                      output logic er, output int we_cyc, output int hold,
                      output logic [31:0] acc_addr, output logic other_ack);
    bit got;
    @(posedge clk); #1;
    wen[d][m]    = we;
    maddr[d][m]  = addr;
    mwdata[d][m] = data;
    req[d][m]    = 1'b1;
    n = 0; we_cyc = 0; hold = 0; other_ack = 1'b0; acc_addr = '0; rd = '0; er = 1'b0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) acc_addr = bus_addr[d];
      if (bus_we[d]) we_cyc++;
      if (mack[d][1-m]) other_ack = 1'b1;
      if (mack[d][m]) begin
        rd  = mrdata[d][m];
        er  = merr[d][m];
        got = 1'b1;
      end else if (bus_addr[d] == addr) begin
        hold++;
      end
    end
    req[d][m] = 1'b0;
    if (!got) n = -1;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({grant[d], bus_we[d], mack[d][0], mack[d][1], merr[d][0], merr[d][1]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: got grant=%b we=%b ack=%b%b err=%b%b expected all 0",
                 d, grant[d], bus_we[d], mack[d][1], mack[d][0], merr[d][1], merr[d][0]);
      end
      checks++;
      if ({bus_addr[d], bus_wdata[d], mrdata[d][0], mrdata[d][1]} !== 128'b0) begin
        errors++;
        $display("FAIL reset_data dut%0d: got addr=%h wdata=%h rd0=%h rd1=%h expected 0",
                 d, bus_addr[d], bus_wdata[d], mrdata[d][0], mrdata[d][1]);
      end
    end
  endtask

  task automatic test_single_read;
    int n, wc, hold; logic [31:0] rd, aa; logic er, oa; exp_t e;
    mem_load(0, 32'h10, 32'hDEADBEEF);
    sb.push_back('{m: 0, data: 32'hDEADBEEF, err: 1'b0});
    xact(0, 0, 1'b0, 32'h10, 32'h0, n, rd, er, wc, hold, aa, oa);
    checks++;
    if (aa !== 32'h10) begin errors++; $display("FAIL read_bus_addr: got %h expected %h", aa, 32'h10); end
    checks++;
    if (wc != 0) begin errors++; $display("FAIL read_bus_we: got %0d write cycles expected 0", wc); end
    checks++;
    if (n != 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", n); end
    e = sb.pop_front();
    checks++;
    if ({rd, er} !== {e.data, e.err}) begin
      errors++; $display("FAIL read_data: got %h err=%b expected %h err=%b", rd, er, e.data, e.err);
    end
  endtask

  task automatic test_write_readback;
    int n, wc, hold; logic [31:0] rd, aa, prev; logic er, oa; exp_t e;
    prev = mrdata[0][1];
    sb.push_back('{m: 1, data: prev, err: 1'b0});
    xact(0, 1, 1'b1, 32'h40, 32'h12345678, n, rd, er, wc, hold, aa, oa);
    checks++;
    if (wc != 1) begin errors++; $display("FAIL write_we_cycles: got %0d expected 1", wc); end
    checks++;
    if (n != 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", n); end
    checks++;
    if (oa !== 1'b0) begin errors++; $display("FAIL write_m0_ack: got %b expected 0", oa); end
    e = sb.pop_front();
    checks++;
    if ({rd, er} !== {e.data, e.err}) begin
      errors++; $display("FAIL write_datain_kept: got %h err=%b expected %h err=%b", rd, er, e.data, e.err);
    end
    sb.push_back('{m: 1, data: 32'h12345678, err: 1'b0});
    xact(0, 1, 1'b0, 32'h40, 32'h0, n, rd, er, wc, hold, aa, oa);
    e = sb.pop_front();
    checks++;
    if ({rd, er} !== {e.data, e.err}) begin
      errors++; $display("FAIL readback_data: got %h err=%b expected %h err=%b", rd, er, e.data, e.err);
    end
    checks++;
    if (oa !== 1'b0 || wc != 0) begin
      errors++; $display("FAIL readback_side: got m0ack=%b we_cycles=%0d expected 0 and 0", oa, wc);
    end
  endtask

  task automatic test_contention;
    int got, cyc; exp_t e; logic [1:0] ackv, expv;
    @(negedge clk);
    rst = 1'b1;
    maddr[0][0] = 32'h10; wen[0][0] = 1'b0;
    maddr[0][1] = 32'h40; wen[0][1] = 1'b0;
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{m: 0, data: 32'hDEADBEEF, err: 1'b0});
      sb.push_back('{m: 1, data: 32'h12345678, err: 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    got = 0; cyc = 0;
    while (got < 6 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (mack[0][0] || mack[0][1]) begin
        e = sb.pop_front();
        ackv = {mack[0][1], mack[0][0]};
        expv = (e.m == 1) ? 2'b10 : 2'b01;
        checks++;
        if (ackv !== expv || grant[0] !== expv) begin
          errors++; $display("FAIL contention_order #%0d: got ack=%b grant=%b expected %b", got, ackv, grant[0], expv);
        end
        checks++;
        if (mrdata[0][e.m] !== e.data) begin
          errors++; $display("FAIL contention_data #%0d: got %h expected %h", got, mrdata[0][e.m], e.data);
        end
        got++;
        if (got == 6) begin req[0][0] = 1'b0; req[0][1] = 1'b0; end
      end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    if (got < 6) begin
      checks++; errors++;
      $display("FAIL contention_timeout: got %0d acks expected 6", got);
      sb.delete();
    end
  endtask

  task automatic test_unaligned;
    int n, wc, hold; logic [31:0] rd, aa, prev; logic er, oa; exp_t e;
    @(posedge clk); #1;
    prev = mrdata[0][0];
    sb.push_back('{m: 0, data: prev, err: 1'b1});
    xact(0, 0, 1'b0, 32'h22, 32'h0, n, rd, er, wc, hold, aa, oa);
    checks++;
    if (n != 1) begin errors++; $display("FAIL unaligned_latency: got %0d expected 1", n); end
    checks++;
    if (wc != 0) begin errors++; $display("FAIL unaligned_we: got %0d write cycles expected 0", wc); end
    e = sb.pop_front();
    checks++;
    if ({rd, er} !== {e.data, e.err}) begin
      errors++; $display("FAIL unaligned_resp: got %h err=%b expected %h err=%b", rd, er, e.data, e.err);
    end
  endtask

  task automatic test_latency3;
    int n, wc, hold; logic [31:0] rd, aa; logic er, oa; exp_t e;
    mem_load(1, 32'h8, 32'hA5A5A5A5);
    sb.push_back('{m: 1, data: 32'hA5A5A5A5, err: 1'b0});
    xact(1, 1, 1'b0, 32'h8, 32'h0, n, rd, er, wc, hold, aa, oa);
    checks++;
    if (hold != 4) begin errors++; $display("FAIL lat3_addr_hold: got %0d expected 4", hold); end
    checks++;
    if (n != 5) begin errors++; $display("FAIL lat3_latency: got %0d expected 5", n); end
    e = sb.pop_front();
    checks++;
    if ({rd, er} !== {e.data, e.err}) begin
      errors++; $display("FAIL lat3_data: got %h err=%b expected %h err=%b", rd, er, e.data, e.err);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    maddr[0][0] = 32'h10; wen[0][0] = 1'b0; req[0][0] = 1'b1;
    @(posedge clk); #1;   // ACCESS
    @(posedge clk); #1;   // WAIT
    rst = 1'b1;
    #1;
    checks++;
    if ({grant[0], bus_we[0], mack[0][0], merr[0][0], bus_addr[0], mrdata[0][0]} !== 68'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got grant=%b we=%b ack=%b err=%b addr=%h rd=%h expected all 0",
               grant[0], bus_we[0], mack[0][0], merr[0][0], bus_addr[0], mrdata[0][0]);
    end
    maddr[0][1] = 32'h40; wen[0][1] = 1'b0; req[0][1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mack[0][0] !== 1'b0) begin errors++; $display("FAIL midreset_no_ack: got %b expected 0", mack[0][0]); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (grant[0] !== 2'b01 || mack[0][0] !== 1'b0) begin
      errors++; $display("FAIL midreset_first_grant: got grant=%b ack=%b expected 01 and 0", grant[0], mack[0][0]);
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; wen[d][m] = 1'b0; maddr[d][m] = '0; mwdata[d][m] = '0;
      end
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_single_read();
    test_write_readback();
    test_contention();
    test_unaligned();
    test_latency3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
